act_window_fifo: RTL

Parametrised successor of the activation input buffer. It is a circular FIFO with one write per cycle, and each read returns a window of NUM_RDATA consecutive entries. After each read it pops a runtime-selectable stride, or pops nothing in peek mode. It adds write backpressure, flush, a programmable threshold, and sticky overflow/underflow flags. It sits between the activation DMA/loader and the PE-array input.

---
 rtl/act_buf_pkg.sv | 34 +++
 rtl/act_ring_mem.sv | 31 +++
 rtl/act_window_fifo.sv | 125 ++++++++++++
 3 files changed

// File: rtl/act_buf_pkg.sv
// Shared definitions for the activation window FIFO: width derivation,
// stride clamping and elaboration-time parameter legality checks.
package act_buf_pkg;

    function automatic int unsigned dat_width(input int unsigned bw, input int unsigned nc);
        return bw * nc;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < longint'(v)) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // A zero stride still consumes one entry; strides beyond the window are capped.
    function automatic int unsigned clamp_stride(input int unsigned s, input int unsigned n);
        if (s == 0) return 1;
        if (s > n) return n;
        return s;
    endfunction

    function automatic bit params_legal(input int unsigned depth, input int unsigned aw,
                                        input int unsigned nrd, input int unsigned sw);
        return (depth == (32'd1 << aw)) && (clog2(depth) == aw) &&
               (nrd >= 1) && (nrd <= depth) && (nrd <= ((32'd1 << sw) - 1));
    endfunction

endpackage

// File: rtl/act_ring_mem.sv
// Register-array ring buffer: one write port and a wrapped multi-entry
// read window starting at the read pointer.
module act_ring_mem #(
    parameter int unsigned DAT_WIDTH     = 24,
    parameter int unsigned FF_DEPTH      = 16,
    parameter int unsigned FF_ADDR_WIDTH = 4,
    parameter int unsigned NUM_RDATA     = 3
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [FF_ADDR_WIDTH-1:0]       waddr_i,
    input  logic [DAT_WIDTH-1:0]           wdata_i,
    input  logic [FF_ADDR_WIDTH-1:0]       rd_ptr_i,
    output logic [DAT_WIDTH*NUM_RDATA-1:0] window_o
);

    logic [DAT_WIDTH-1:0] mem_q [FF_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Address arithmetic wraps naturally at FF_ADDR_WIDTH bits.
    always_comb begin
        window_o = '0;
        for (int unsigned k = 0; k < NUM_RDATA; k++) begin
            window_o[k*DAT_WIDTH +: DAT_WIDTH] = mem_q[rd_ptr_i + FF_ADDR_WIDTH'(k)];
        end
    end

endmodule

// File: rtl/act_window_fifo.sv
// Activation window FIFO: single write per cycle, windowed read with
// runtime stride or peek, flush, threshold flag and sticky error flags.
module act_window_fifo
    import act_buf_pkg::*;
#(
    parameter int unsigned BIT_WIDTH     = 8,
    parameter int unsigned NUM_CHANNEL   = 3,
    parameter int unsigned NUM_RDATA     = 3,
    parameter int unsigned FF_DEPTH      = 16,
    parameter int unsigned FF_ADDR_WIDTH = 4,
    parameter int unsigned STRIDE_WIDTH  = 2,
    parameter int unsigned HALF_THR      = FF_DEPTH * 3 / 4,
    parameter int unsigned DAT_WIDTH     = dat_width(BIT_WIDTH, NUM_CHANNEL)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DAT_WIDTH-1:0]           i_data,
    input  logic                           i_data_vld,
    output logic                           o_data_rdy,
    input  logic                           i_data_req,
    input  logic [STRIDE_WIDTH-1:0]        i_stride,
    input  logic                           i_peek,
    input  logic                           i_flush,
    output logic [DAT_WIDTH*NUM_RDATA-1:0] o_data,
    output logic                           o_data_vld,
    output logic [FF_ADDR_WIDTH:0]         data_counter,
    output logic                           o_empty,
    output logic                           o_full,
    output logic                           o_half,
    output logic                           o_ovf,
    output logic                           o_udf
);

    localparam int unsigned CW = FF_ADDR_WIDTH + 1;
    localparam int unsigned OW = DAT_WIDTH * NUM_RDATA;

    if (!params_legal(FF_DEPTH, FF_ADDR_WIDTH, NUM_RDATA, STRIDE_WIDTH)) begin : g_bad_params
        $error("act_window_fifo: illegal parameter combination");
    end

    logic [FF_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            cnt_q, cnt_d, pop;
    logic [OW-1:0]            data_q, data_d, window;
    logic                     vld_q, vld_d, ovf_q, ovf_d, udf_q, udf_d;
    logic                     full, wr_acc, rd_acc;

    assign full       = (cnt_q == CW'(FF_DEPTH));
    assign wr_acc     = i_data_vld && !full;
    assign rd_acc     = i_data_req && (cnt_q >= CW'(NUM_RDATA));

    assign o_data_rdy   = !full;
    assign o_full       = full;
    assign o_empty      = (cnt_q == '0);
    assign o_half       = (cnt_q > CW'(HALF_THR));
    assign o_data       = data_q;
    assign o_data_vld   = vld_q;
    assign data_counter = cnt_q;
    assign o_ovf        = ovf_q;
    assign o_udf        = udf_q;

    act_ring_mem #(
        .DAT_WIDTH    (DAT_WIDTH),
        .FF_DEPTH     (FF_DEPTH),
        .FF_ADDR_WIDTH(FF_ADDR_WIDTH),
        .NUM_RDATA    (NUM_RDATA)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc && !i_flush && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (i_data),
        .rd_ptr_i(rd_ptr_q),
        .window_o(window)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        pop      = '0;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            data_d   = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (rd_acc && !i_peek) pop = CW'(clamp_stride(32'(i_stride), NUM_RDATA));
            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) begin
                data_d = window;
                vld_d  = 1'b1;
            end
            rd_ptr_d = rd_ptr_q + pop[FF_ADDR_WIDTH-1:0];
            cnt_d    = cnt_q + CW'(wr_acc) - pop;
            ovf_d    = ovf_q | (i_data_vld & full);
            udf_d    = udf_q | (i_data_req & !rd_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule
